// File: rtl/sst_ctrl.sv
// -----------------------------------------------------------------------------
// sst_ctrl : front-end controller for the store set table (SST).
//
// Two independent round-robin arbiters share the SST's single new-SSID port and
// single touch port between REQ_COUNT requesters. A clear FSM periodically (or
// on force_clear) blocks traffic, lets the last response drain, and holds a
// clear request to the SST until it reports completion.
//
// State table:
//   S_IDLE  | normal traffic, period counter running
//   S_DRAIN | traffic blocked, waiting for the in-flight new-SSID response
//   S_CLEAR | sst_clear_valid held high until sst_clear_done
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   new_req_valid/ready        per-requester new-SSID request / one-hot grant
//   new_resp_*                 registered SSID return, 1 cycle after grant
//   touch_req_valid/SSID/ready per-requester touch request / one-hot grant
//   sst_new_SSID_valid/SSID    SST allocation port (SSID returned same cycle)
//   sst_touch_SSID_valid/SSID  SST touch port
//   sst_clear_valid/done       SST clear handshake
//   force_clear                request an immediate clear sequence
//   clear_busy                 high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module sst_ctrl #(
    parameter int STORE_SET_COUNT = 64,
    parameter int REQ_COUNT       = 2,
    parameter int CLEAR_PERIOD    = 65536,
    localparam int SSID_WIDTH     = $clog2(STORE_SET_COUNT),
    localparam int IDX_WIDTH      = $clog2(REQ_COUNT)
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic [REQ_COUNT-1:0]            new_req_valid,
    output logic [REQ_COUNT-1:0]            new_req_ready,
    output logic                            new_resp_valid,
    output logic [IDX_WIDTH-1:0]            new_resp_req_idx,
    output logic [SSID_WIDTH-1:0]           new_resp_SSID,
    input  logic [REQ_COUNT-1:0]            touch_req_valid,
    input  logic [REQ_COUNT*SSID_WIDTH-1:0] touch_req_SSID,
    output logic [REQ_COUNT-1:0]            touch_req_ready,
    output logic                            sst_new_SSID_valid,
    input  logic [SSID_WIDTH-1:0]           sst_new_SSID,
    output logic                            sst_touch_SSID_valid,
    output logic [SSID_WIDTH-1:0]           sst_touch_SSID,
    output logic                            sst_clear_valid,
    input  logic                            sst_clear_done,
    input  logic                            force_clear,
    output logic                            clear_busy
);

    localparam int CNT_WIDTH = (CLEAR_PERIOD > 2) ? $clog2(CLEAR_PERIOD) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_clear_busy;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [IDX_WIDTH-1:0]   r_rr_new_ptr;
    logic [IDX_WIDTH-1:0]   r_rr_touch_ptr;
    logic                   r_resp_valid;
    logic [IDX_WIDTH-1:0]   r_resp_idx;
    logic [SSID_WIDTH-1:0]  r_resp_ssid;

    logic                   w_grant_en;
    logic                   w_period_hit;
    logic                   w_start_clear;
    logic [IDX_WIDTH:0]     w_new_pick;
    logic [IDX_WIDTH:0]     w_touch_pick;
    logic                   w_new_gnt;
    logic                   w_touch_gnt;
    logic [IDX_WIDTH-1:0]   w_new_idx;
    logic [IDX_WIDTH-1:0]   w_touch_idx;

    // Returns {found, index} of the first set bit at or above ptr, wrapping.
    function automatic logic [IDX_WIDTH:0] rr_pick(
        input logic [REQ_COUNT-1:0] v,
        input logic [IDX_WIDTH-1:0] ptr
    );
        logic                 found;
        logic [IDX_WIDTH-1:0] idx;
        int                   j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            j = int'(ptr) + i;
            if (j >= REQ_COUNT) j = j - REQ_COUNT;
            if (!found && v[IDX_WIDTH'(j)]) begin
                found = 1'b1;
                idx   = IDX_WIDTH'(j);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [IDX_WIDTH-1:0] ptr_after(input logic [IDX_WIDTH-1:0] g);
        return (int'(g) == REQ_COUNT - 1) ? '0 : IDX_WIDTH'(int'(g) + 1);
    endfunction

    // Gating with nRST keeps every output low while reset is held, even with
    // requests pending against the (already reset) IDLE state.
    assign w_grant_en    = nRST && (r_state == S_IDLE);
    assign w_period_hit  = (r_cnt == CNT_WIDTH'(CLEAR_PERIOD - 1));
    assign w_start_clear = w_period_hit || force_clear;

    assign w_new_pick    = rr_pick(new_req_valid, r_rr_new_ptr);
    assign w_touch_pick  = rr_pick(touch_req_valid, r_rr_touch_ptr);
    assign w_new_gnt     = w_grant_en && w_new_pick[IDX_WIDTH];
    assign w_touch_gnt   = w_grant_en && w_touch_pick[IDX_WIDTH];
    assign w_new_idx     = w_new_pick[IDX_WIDTH-1:0];
    assign w_touch_idx   = w_touch_pick[IDX_WIDTH-1:0];

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_IDLE;
            r_clear_busy <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clear_busy <= (w_state_nxt != S_IDLE);
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_clear)   w_state_nxt = S_DRAIN;
            S_DRAIN: if (!r_resp_valid)   w_state_nxt = S_CLEAR;
            S_CLEAR: if (sst_clear_done)  w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    // FSM / arbiter outputs
    always_comb begin
        new_req_ready        = '0;
        sst_new_SSID_valid   = 1'b0;
        touch_req_ready      = '0;
        sst_touch_SSID_valid = 1'b0;
        sst_touch_SSID       = '0;
        if (w_new_gnt) begin
            new_req_ready[w_new_idx] = 1'b1;
            sst_new_SSID_valid       = 1'b1;
        end
        if (w_touch_gnt) begin
            touch_req_ready[w_touch_idx] = 1'b1;
            sst_touch_SSID_valid         = 1'b1;
            sst_touch_SSID = touch_req_SSID[w_touch_idx*SSID_WIDTH +: SSID_WIDTH];
        end
    end

    assign sst_clear_valid = (r_state == S_CLEAR);
    assign clear_busy      = r_clear_busy;

    // Period counter: runs only in IDLE, zeroed on entry to DRAIN.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) && !w_start_clear) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Round-robin pointers and the registered new-SSID response.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr_new_ptr   <= '0;
            r_rr_touch_ptr <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_idx     <= '0;
            r_resp_ssid    <= '0;
        end else begin
            r_resp_valid <= w_new_gnt;
            if (w_new_gnt) begin
                r_rr_new_ptr <= ptr_after(w_new_idx);
                r_resp_idx   <= w_new_idx;
                r_resp_ssid  <= sst_new_SSID;
            end
            if (w_touch_gnt) begin
                r_rr_touch_ptr <= ptr_after(w_touch_idx);
            end
        end
    end

    assign new_resp_valid   = r_resp_valid;
    assign new_resp_req_idx = r_resp_idx;
    assign new_resp_SSID    = r_resp_ssid;

endmodule
